// File: rtl/bmf_pkg.sv
// Shared types and limits for the BMF factor decoder.
package bmf_pkg;

  typedef enum logic [1:0] {
    CFG   = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } bmf_state_e;

  // Reduction selector for the row combine.
  localparam int BMF_OR  = 0;
  localparam int BMF_XOR = 1;

  localparam int BMF_MAX_K = 16;
  localparam int BMF_MAX_M = 64;

endpackage

// File: rtl/bmf_row_combine.sv
// Boolean product of a K-bit factor with a KxM basis; one reduction lane per column.
module bmf_row_combine
  import bmf_pkg::*;
#(
  parameter int K        = 1,
  parameter int M        = 5,
  parameter int XOR_MODE = BMF_OR
) (
  input  logic [K-1:0]        k,
  input  logic [K-1:0][M-1:0] basis,
  output logic [M-1:0]        y
);

  for (genvar j = 0; j < M; j++) begin : g_col
    logic [K-1:0] terms;
    for (genvar i = 0; i < K; i++) begin : g_row
      assign terms[i] = k[i] & basis[i][j];
    end
    assign y[j] = (XOR_MODE == BMF_XOR) ? ^terms : |terms;
  end

endmodule

// File: rtl/bmf_factor_decoder.sv
// Streaming BMF reconstruction: runtime-loaded basis, 2-stage stall pipeline.
module bmf_factor_decoder
  import bmf_pkg::*;
#(
  parameter int K        = 1,
  parameter int M        = 5,
  parameter int XOR_MODE = BMF_OR,
  localparam int RW      = (K > 1) ? $clog2(K) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [RW-1:0] cfg_row,
  input  logic [M-1:0]  cfg_data,
  input  logic          cfg_commit,
  input  logic          cfg_req,
  output logic          cfg_ok,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [K-1:0]  in_k,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [M-1:0]  out_y,
  output logic [31:0]   out_count
);

  bmf_state_e          state;
  logic [K-1:0][M-1:0] basis;
  logic [K-1:0]        mask;
  logic [K-1:0]        wr_hot;
  logic [2:1]          vld_pipe;
  logic [K-1:0]        s1_k;
  logic [M-1:0]        prod;
  logic                s1_load, s2_load, acc;

  // One-hot row write; out-of-range rows match no bit and are dropped.
  always_comb begin
    wr_hot = '0;
    for (int i = 0; i < K; i++)
      wr_hot[i] = cfg_we & (state == CFG) & (int'(cfg_row) == i);
  end

  assign s2_load  = !vld_pipe[2] | out_ready;
  assign s1_load  = !vld_pipe[1] | s2_load;
  assign in_ready = (state == RUN) & s1_load;
  assign acc      = in_valid & in_ready;
  assign out_valid = vld_pipe[2];

  // Basis rows and written-row mask; the mask survives DRAIN so partial rewrites can commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      basis <= '0;
      mask  <= '0;
    end else begin
      mask <= mask | wr_hot;
      for (int i = 0; i < K; i++)
        if (wr_hot[i]) basis[i] <= cfg_data;
    end
  end

  // Mode FSM; a same-cycle write counts toward the commit check.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= CFG;
      cfg_ok <= 1'b0;
    end else begin
      case (state)
        CFG: if (cfg_commit && (&(mask | wr_hot))) begin
          state  <= RUN;
          cfg_ok <= 1'b1;
        end
        RUN: if (cfg_req) begin
          state  <= DRAIN;
          cfg_ok <= 1'b0;
        end
        DRAIN: if (vld_pipe == 2'b00) state <= CFG;
        default: begin
          state  <= CFG;
          cfg_ok <= 1'b0;
        end
      endcase
    end
  end

  bmf_row_combine #(.K(K), .M(M), .XOR_MODE(XOR_MODE)) u_comb (
    .k     (s1_k),
    .basis (basis),
    .y     (prod)
  );

  // S1 holds the factor, S2 holds the product; each stage advances only when its successor can take it.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_k     <= '0;
      out_y    <= '0;
    end else begin
      if (s1_load) begin
        vld_pipe[1] <= acc;
        if (acc) s1_k <= in_k;
      end
      if (s2_load) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) out_y <= prod;
      end
    end
  end

  // Delivered-vector counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) out_count <= '0;
    else if (out_valid && out_ready) out_count <= out_count + 32'd1;
  end

endmodule

// File: tb/tb_bmf_factor_decoder.sv
// Bench: K=3/M=4 decoders in XOR and OR modes sharing stimulus, plus a K=1/M=5 OR decoder.
module tb_bmf_factor_decoder;
  import bmf_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cfg_we, cfg_commit, cfg_req, in_valid, out_ready;
  logic [1:0]  cfg_row;
  logic [3:0]  cfg_data;
  logic [2:0]  in_k;
  logic        cfg_ok_x, in_ready_x, out_valid_x, cfg_ok_o, in_ready_o, out_valid_o;
  logic [3:0]  out_y_x, out_y_o;
  logic [31:0] out_count_x, out_count_o;

  logic        cfg_we1, cfg_commit1, cfg_req1, in_valid1, out_ready1;
  logic [0:0]  cfg_row1, in_k1;
  logic [4:0]  cfg_data1, out_y1;
  logic        cfg_ok1, in_ready1, out_valid1;
  logic [31:0] out_count1;

  bmf_factor_decoder #(.K(3), .M(4), .XOR_MODE(BMF_XOR)) u_x (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_req(cfg_req), .cfg_ok(cfg_ok_x), .in_valid(in_valid),
    .in_ready(in_ready_x), .in_k(in_k), .out_valid(out_valid_x), .out_ready(out_ready),
    .out_y(out_y_x), .out_count(out_count_x));

  bmf_factor_decoder #(.K(3), .M(4), .XOR_MODE(BMF_OR)) u_o (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_req(cfg_req), .cfg_ok(cfg_ok_o), .in_valid(in_valid),
    .in_ready(in_ready_o), .in_k(in_k), .out_valid(out_valid_o), .out_ready(out_ready),
    .out_y(out_y_o), .out_count(out_count_o));

  bmf_factor_decoder #(.K(1), .M(5), .XOR_MODE(BMF_OR)) u_1 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we1), .cfg_row(cfg_row1), .cfg_data(cfg_data1),
    .cfg_commit(cfg_commit1), .cfg_req(cfg_req1), .cfg_ok(cfg_ok1), .in_valid(in_valid1),
    .in_ready(in_ready1), .in_k(in_k1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_y(out_y1), .out_count(out_count1));

  int         n_assert = 0, n_fail = 0, ndel = 0;
  logic [3:0] bm [3];
  logic [2:0] q [$];
  logic       held = 1'b0;
  logic [3:0] hx, ho;
  logic       last_acc;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: fold selected basis rows together, row by row.
  function automatic logic [3:0] ref_y(logic [2:0] k, bit use_xor);
    logic [3:0] y = 4'b0;
    for (int i = 0; i < 3; i++)
      if (k[i]) y = use_xor ? (y ^ bm[i]) : (y | bm[i]);
    return y;
  endfunction

  // One clock of the shared K=3 stimulus with scoreboard and stall-hold checks.
  task automatic cyc();
    logic dlv;
    #1;
    last_acc = in_valid & in_ready_x;
    if (held) begin
      chk("hold_valid", out_valid_x, 1);
      chk("hold_y_xor", out_y_x, hx);
      chk("hold_y_or", out_y_o, ho);
    end
    dlv = out_valid_x & out_ready;
    if (dlv) begin
      if (q.size() == 0) chk("out_without_input", out_valid_x, 0);
      else begin
        chk("y_xor", out_y_x, ref_y(q[0], 1'b1));
        chk("y_or", out_y_o, ref_y(q[0], 1'b0));
        void'(q.pop_front());
        ndel++;
      end
    end
    held = out_valid_x & !out_ready;
    hx = out_y_x;
    ho = out_y_o;
    if (last_acc) q.push_back(in_k);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(int r, logic [3:0] d, bit commit, bit lands);
    cfg_we = 1'b1; cfg_row = 2'(r); cfg_data = d; cfg_commit = commit;
    cyc();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    if (lands) bm[r] = d;
  endtask

  task automatic drain(string tag);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 20 && q.size() > 0; n++) cyc();
    chk({tag, "_empty"}, 64'(q.size()), 0);
    chk({tag, "_count"}, out_count_x, 64'(ndel));
  endtask

  task automatic tk();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc_n;
    rst = 1'b1;
    cfg_we = 0; cfg_commit = 0; cfg_req = 0; in_valid = 0; out_ready = 0;
    cfg_row = 0; cfg_data = 0; in_k = 0;
    cfg_we1 = 0; cfg_commit1 = 0; cfg_req1 = 0; in_valid1 = 0; out_ready1 = 0;
    cfg_row1 = 0; cfg_data1 = 0; in_k1 = 0;
    for (int i = 0; i < 3; i++) bm[i] = 4'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready_x, 0);
    chk("rst_out_valid", out_valid_x, 0);
    chk("rst_out_y", out_y_x, 0);
    chk("rst_cfg_ok", cfg_ok_x, 0);
    chk("rst_out_count", out_count_x, 0);
    rst = 1'b0;

    // K=1, OR: row0 = 10001, stream 1,0,1
    cfg_we1 = 1; cfg_row1 = 0; cfg_data1 = 5'b10001; cfg_commit1 = 1;
    tk();
    cfg_we1 = 0; cfg_commit1 = 0;
    chk("k1_cfg_ok", cfg_ok1, 1);
    out_ready1 = 1; in_valid1 = 1; in_k1 = 1'b1;
    chk("k1_in_ready", in_ready1, 1);
    tk(); in_k1 = 1'b0;
    chk("k1_lat_c1", out_valid1, 0);
    tk(); in_k1 = 1'b1;
    chk("k1_v_c2", out_valid1, 1);
    chk("k1_y_c2", out_y1, 5'b10001);
    tk(); in_valid1 = 0;
    chk("k1_y_c3", out_y1, 5'b00000);
    tk();
    chk("k1_y_c4", out_y1, 5'b10001);
    tk();
    chk("k1_v_end", out_valid1, 0);
    chk("k1_count", out_count1, 3);

    // K=3 config: partial mask and an out-of-range row must not allow commit
    out_ready = 1;
    wr(0, 4'b0011, 0, 1);
    wr(1, 4'b0110, 0, 1);
    wr(3, 4'b1111, 1, 0);
    chk("partial_cfg_ok", cfg_ok_x, 0);
    chk("partial_in_ready", in_ready_x, 0);
    wr(2, 4'b1100, 1, 1);
    chk("commit_cfg_ok_x", cfg_ok_x, 1);
    chk("commit_cfg_ok_o", cfg_ok_o, 1);

    // Single vector 111: latency 2, XOR 1001 / OR 1111
    in_valid = 1; in_k = 3'b111;
    cyc();
    in_valid = 0;
    chk("lat_c1", out_valid_x, 0);
    cyc();
    chk("lat_c2", out_valid_x, 1);
    chk("y111_xor", out_y_x, 4'b1001);
    chk("y111_or", out_y_o, 4'b1111);
    cyc();
    chk("count_1", out_count_x, 1);

    // Backpressure: 5 stalled cycles, only 2 accepted, then release
    out_ready = 0; acc_n = 0;
    for (int n = 0; n < 5; n++) begin
      in_valid = 1; in_k = 3'($urandom);
      cyc();
      if (last_acc) acc_n++;
    end
    chk("stall_accepts", 64'(acc_n), 2);
    chk("stall_in_ready", in_ready_x, 0);
    out_ready = 1;
    for (int n = 0; n < 20 && acc_n < 4; n++) begin
      in_valid = 1; in_k = 3'($urandom);
      cyc();
      if (last_acc) acc_n++;
    end
    chk("stall_total_acc", 64'(acc_n), 4);
    drain("stall");

    // Random streaming with random backpressure
    for (int n = 0; n < 300; n++) begin
      in_valid = 1'($urandom); in_k = 3'($urandom); out_ready = ($urandom % 4) != 0;
      cyc();
    end
    drain("rand");

    // cfg_req with two vectors in flight
    out_ready = 0;
    in_valid = 1; in_k = 3'($urandom); cyc();
    in_k = 3'($urandom); cyc();
    in_valid = 0;
    chk("req_inflight", 64'(q.size()), 2);
    cfg_req = 1; cyc(); cfg_req = 0;
    out_ready = 1; in_valid = 1;
    for (int n = 0; n < 10 && q.size() > 0; n++) begin
      chk("drain_in_ready", in_ready_x, 0);
      cyc();
    end
    drain("req");
    wr(0, 4'b1111, 1, 0);
    chk("drain_still", cfg_ok_x, 0);
    wr(0, 4'b1010, 1, 1);
    chk("recommit", cfg_ok_x, 1);
    in_valid = 1; in_k = 3'b001; cyc();
    in_k = 3'b011; cyc();
    drain("newbasis");

    // Reset mid-stream with out_valid high
    out_ready = 0; in_valid = 1; in_k = 3'($urandom);
    cyc(); cyc();
    in_valid = 0;
    chk("pre_rst_valid", out_valid_x, 1);
    rst = 1; tk(); rst = 0;
    q.delete(); ndel = 0; held = 0;
    for (int i = 0; i < 3; i++) bm[i] = 4'b0;
    out_ready = 1;
    chk("mid_rst_valid", out_valid_x, 0);
    chk("mid_rst_count", out_count_x, 0);
    chk("mid_rst_cfg_ok", cfg_ok_x, 0);
    chk("mid_rst_in_ready", in_ready_x, 0);
    wr(0, 4'b0101, 0, 1);
    wr(1, 4'b1001, 1, 1);
    chk("post_rst_partial", cfg_ok_x, 0);
    wr(2, 4'b0111, 1, 1);
    chk("post_rst_commit", cfg_ok_x, 1);
    for (int n = 0; n < 40; n++) begin
      in_valid = 1'($urandom); in_k = 3'($urandom); out_ready = 1'($urandom);
      cyc();
    end
    drain("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bmf_factor_decoder.md
# bmf_factor_decoder

Streaming reconstruction engine for the approximate-logic flow: takes the compressed K-bit factor vectors that the compressor half of a Boolean-matrix-factorized partition emits and rebuilds the M-bit output vector as the Boolean product of the factor with a runtime-loaded K×M basis matrix. It is the hardware counterpart of the per-partition combinational decoder. It lets one instance serve any partition by reloading the basis instead of re-synthesizing the decoder. It sits between a factor source (compressor or test vector memory) and the output comparator/error-measurement logic.

## Interface
- K, default 1: factor width, i.e. the number of basis rows, 1..16.
- M, default 5: output vector width, 1..64.
- XOR_MODE, default 0: 0 = Boolean semiring (OR of ANDs); 1 = GF(2) (XOR of ANDs).
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  basis row write strobe.
- cfg_row  in  $clog2(K) (min 1)  row index for cfg_we.
- cfg_data  in  M  basis row contents; bit j is column j.
- cfg_commit  in  1  request transition CFG→RUN.
- cfg_req  in  1  request return to CFG from RUN.
- cfg_ok  out  1  high while in RUN.
- in_valid  in  1  factor vector valid.
- in_ready  out  1  factor vector accepted when in_valid & in_ready.
- in_k  in  K  factor vector; bit i selects basis row i.
- out_valid  out  1  reconstructed vector valid.
- out_ready  in  1  downstream accepts when out_valid & out_ready.
- out_y  out  M  reconstructed output vector.
- out_count  out  32  number of vectors delivered since the last rst.

## Operation
- States: CFG, RUN, DRAIN. Reset enters CFG. Basis registers are cleared to 0, the row-written mask is cleared, and out_count is set to 0.
- CFG: in_ready=0. A cfg_we with cfg_row<K writes the row and sets its mask bit. A cfg_we with cfg_row≥K is ignored. cfg_commit moves to RUN on the next cycle only if all K mask bits are set; otherwise it is ignored. If cfg_we and cfg_commit occur in the same cycle, the write lands first and then counts toward the mask check.
- RUN: streaming. cfg_we is ignored. cfg_req moves to DRAIN; no further input is accepted from that cycle on.
- DRAIN: in_ready=0. Move to CFG in the cycle after both pipeline stages are empty. The mask is retained, so a partial rewrite followed by commit is legal.
- Product: out_y[j] = reduce_i(in_k[i] & basis[i][j]). The reduction is OR when XOR_MODE=0 and XOR when XOR_MODE=1. An all-zero in_k gives 0.
- cfg_ok = (state==RUN).
- out_count increments once per out handshake and wraps 2^32−1→0.

## Timing
- Two-stage stall pipeline:
  - S1 registers in_k.
  - S2 registers the product.
- Latency is 2 cycles from input handshake to out_valid when out_ready is held high. Full throughput is 1 vector/cycle.
- S2 loads when !s2_valid | out_ready.
- S1 loads when !s1_valid | S2 loads.
- in_ready = (state==RUN) & S1-load condition. The combinational path from out_ready to in_ready is intentional.
- out_valid must never drop, and out_y must never change, while out_valid & !out_ready.
- rst in any state, including mid-stream or mid-drain, clears both valids, the state and the counter in the same cycle edge. Nothing in flight is delivered afterward.
- Reset values: in_ready=0, out_valid=0, out_y=0, cfg_ok=0, out_count=0.
- The basis read by S2 is the current register. It cannot change while S1/S2 are occupied, because writes are only possible in CFG.

## Structure
- Package bmf_pkg holds:
  - the state enum (CFG, RUN, DRAIN);
  - the XOR_MODE encoding constants (BMF_OR=0, BMF_XOR=1);
  - the max-K/max-M limits.
- Sub-module bmf_row_combine: purely combinational K×M product with an XOR_MODE parameter. It is instanced once, between S1 and S2.
- The top level holds the FSM, basis registers, write mask, pipeline valids and counter.

## Test plan
- K=1, M=5, OR mode, row0=5'b10001, commit, then stream in_k=1,0,1 → out_y=10001,00000,10001 on cycles 2,3,4 after the first handshake; out_count=3.
- K=3, M=4, XOR mode, rows 0011/0110/1100, in_k=3'b111 → 1001. Same inputs in OR mode → 1111.
- Commit with only rows 0,1 of K=3 written → cfg_ok stays 0 and in_ready stays 0. Write row 2 together with commit in one cycle → RUN next cycle.
- Stream 4 vectors with out_ready held low for 5 cycles:
  - out_valid/out_y held stable;
  - in_ready drops after 2 accepted;
  - release → all 4 delivered in order, no loss or duplication.
- cfg_req with 2 vectors in flight:
  - no new accept;
  - both delivered;
  - state reaches CFG one cycle after empty;
  - rewrite row 0 and commit → new basis used.
- Assert rst for one cycle mid-stream with out_valid=1:
  - next cycle out_valid=0, out_count=0, state CFG;
  - commit is refused until all rows are rewritten.
